// File: rtl/test_seq_ctrl.sv
// Multi-channel stimulus/response test sequencer: powers the DUT, drives DAC words
// per channel, checks the tagged ADC loopback. Optional TEST_SEQ_CMP_MASK_EN adds cmp_mask.
module test_seq_ctrl #(
  parameter int DATA_W  = 16,
  parameter int NCH     = 4,
  parameter int CNT_W   = 32,
  parameter int ERR_W   = 16,
  parameter int PWR_DLY = 8,
  parameter int TIMEOUT = 64,
  localparam int CH_W   = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        test_mode,
  input  logic [CNT_W-1:0]  max_cycles,
  input  logic [DATA_W-1:0] stim_pattern,
`ifdef TEST_SEQ_CMP_MASK_EN
  input  logic [DATA_W-1:0] cmp_mask,
`endif
  input  logic              dac_ready,
  input  logic              adc_valid,
  input  logic [CH_W-1:0]   adc_ch,
  input  logic [DATA_W-1:0] adc_data,
  output logic              dac_valid,
  output logic [CH_W-1:0]   dac_ch,
  output logic [DATA_W-1:0] dac_data,
  output logic              power_en,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  error_count,
  output logic [ERR_W-1:0]  timeout_count,
  output logic [CH_W-1:0]   first_err_ch,
  output logic [CNT_W-1:0]  first_err_cycle
);

  localparam int TMR_MAX = (PWR_DLY > TIMEOUT) ? PWR_DLY : TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int STEP_W  = $clog2(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_PWR_UP, S_DRIVE, S_WAIT_ADC, S_CHECK, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [CNT_W-1:0]    max_q, max_d;
  logic [DATA_W-1:0]   pat_q, pat_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                dac_valid_q, dac_valid_d;
  logic                power_en_q, power_en_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [ERR_W-1:0]    to_q, to_d;
  logic [CH_W-1:0]     fe_ch_q, fe_ch_d;
  logic [CNT_W-1:0]    fe_cyc_q, fe_cyc_d;
  logic [DATA_W-1:0]   adc_q, adc_d;
  logic                counted_q, counted_d;

  logic [DATA_W-1:0]   stim;
  logic                mismatch;
  logic [ERR_W-1:0]    err_inc, to_inc;
  logic                last_ch, last_word;

  always_comb begin
    case (mode_q)
      2'b00:   stim = pat_q;
      2'b10:   stim = DATA_W'(1) << step_q;
      default: stim = cyc_q[0] ? ~pat_q : pat_q;
    endcase
  end

`ifdef TEST_SEQ_CMP_MASK_EN
  assign mismatch = |((adc_q ^ stim) & mask_q);
`else
  assign mismatch = (adc_q != stim);
`endif

  assign err_inc   = (&err_q) ? err_q : err_q + ERR_W'(1);
  assign to_inc    = (&to_q)  ? to_q  : to_q + ERR_W'(1);
  assign last_ch   = (ch_q == CH_W'(NCH - 1));
  assign last_word = last_ch && ((mode_q == 2'b00) ||
                     ((mode_q != 2'b11) && (cyc_q == max_q - CNT_W'(1))));

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    max_d       = max_q;
    pat_d       = pat_q;
    mask_d      = mask_q;
    ch_d        = ch_q;
    cyc_d       = cyc_q;
    step_d      = step_q;
    timer_d     = timer_q;
    dac_valid_d = dac_valid_q;
    power_en_d  = power_en_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    to_d        = to_q;
    fe_ch_d     = fe_ch_q;
    fe_cyc_d    = fe_cyc_q;
    adc_d       = adc_q;
    counted_d   = counted_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          mode_d     = test_mode;
          max_d      = (max_cycles == '0) ? CNT_W'(1) : max_cycles;
          pat_d      = stim_pattern;
`ifdef TEST_SEQ_CMP_MASK_EN
          mask_d     = cmp_mask;
`endif
          err_d      = '0;
          to_d       = '0;
          fe_ch_d    = '0;
          fe_cyc_d   = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          power_en_d = 1'b1;
          timer_d    = '0;
          state_d    = S_PWR_UP;
        end
      end
      S_PWR_UP: begin
        if (timer_q == TMR_W'(PWR_DLY - 1)) begin
          ch_d        = '0;
          cyc_d       = '0;
          step_d      = '0;
          timer_d     = '0;
          dac_valid_d = 1'b1;
          state_d     = S_DRIVE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_DRIVE: begin
        if (dac_valid_q && dac_ready) begin
          dac_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = S_WAIT_ADC;
        end
      end
      S_WAIT_ADC: begin
        if (adc_valid && (adc_ch == ch_q)) begin
          adc_d     = adc_data;
          counted_d = 1'b0;
          state_d   = S_CHECK;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          // Timeout is scored here so CHECK must skip the data compare.
          to_d      = to_inc;
          err_d     = err_inc;
          if (err_q == '0) begin
            fe_ch_d  = ch_q;
            fe_cyc_d = cyc_q;
          end
          counted_d = 1'b1;
          state_d   = S_CHECK;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_CHECK: begin
        if (!counted_q && mismatch) begin
          err_d = err_inc;
          if (err_q == '0) begin
            fe_ch_d  = ch_q;
            fe_cyc_d = cyc_q;
          end
        end
        step_d = (step_q == STEP_W'(DATA_W - 1)) ? '0 : step_q + STEP_W'(1);
        if (last_ch) begin
          ch_d  = '0;
          cyc_d = cyc_q + CNT_W'(1);
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
        if (last_word) begin
          done_d  = 1'b1;
          pass_d  = (err_d == '0) && (to_q == '0);
          state_d = S_DONE;
        end else begin
          dac_valid_d = 1'b1;
          state_d     = S_DRIVE;
        end
      end
      S_DONE: begin
        power_en_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides any same-cycle handshake or match; statistics stay frozen.
    if (abort && (state_q != S_IDLE)) begin
      err_d       = err_q;
      to_d        = to_q;
      fe_ch_d     = fe_ch_q;
      fe_cyc_d    = fe_cyc_q;
      dac_valid_d = 1'b0;
      power_en_d  = 1'b0;
      done_d      = 1'b1;
      pass_d      = 1'b0;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      max_q       <= '0;
      pat_q       <= '0;
      mask_q      <= '0;
      ch_q        <= '0;
      cyc_q       <= '0;
      step_q      <= '0;
      timer_q     <= '0;
      dac_valid_q <= 1'b0;
      power_en_q  <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      to_q        <= '0;
      fe_ch_q     <= '0;
      fe_cyc_q    <= '0;
      adc_q       <= '0;
      counted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      max_q       <= max_d;
      pat_q       <= pat_d;
      mask_q      <= mask_d;
      ch_q        <= ch_d;
      cyc_q       <= cyc_d;
      step_q      <= step_d;
      timer_q     <= timer_d;
      dac_valid_q <= dac_valid_d;
      power_en_q  <= power_en_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      to_q        <= to_d;
      fe_ch_q     <= fe_ch_d;
      fe_cyc_q    <= fe_cyc_d;
      adc_q       <= adc_d;
      counted_q   <= counted_d;
    end
  end

  assign dac_valid       = dac_valid_q;
  assign dac_ch          = ch_q;
  assign dac_data        = stim;
  assign power_en        = power_en_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;
  assign pass            = pass_q;
  assign error_count     = err_q;
  assign timeout_count   = to_q;
  assign first_err_ch    = fe_ch_q;
  assign first_err_cycle = fe_cyc_q;

endmodule

// File: doc/test_seq_ctrl.md
Name: test_seq_ctrl

Overview:
- Parametrised multi-channel stimulus/response test sequencer.
- Powers up the DUT and drives per-channel patterns to the DAC via a valid/ready handshake, then waits for the tagged ADC loopback.
- Compares the ADC sample against the expected value and accumulates error and timeout statistics.
- Sits between the test host registers and the DAC/ADC front-end; successor to the single-channel fixed-pattern test FSM.

Parameters:
- DATA_W, 16: DAC/ADC sample width.
- NCH, 4: channel count, must be ≥2. Derived localparam CH_W = $clog2(NCH).
- CNT_W, 32: cycle counter and max_cycles width.
- ERR_W, 16: error_count and timeout_count width.
- PWR_DLY, 8: cycles between power_en rising and the first DAC transfer; must be ≥1.
- TIMEOUT, 64: WAIT_ADC cycles before a timeout; must be ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin test; single-cycle pulse, sampled in IDLE only.
- abort  in  1  terminate the test.
- test_mode  in  2  00 single pass, 01 N-cycle alternating, 10 N-cycle walking-ones, 11 free-run alternating.
- max_cycles  in  CNT_W  cycle count N; latched at start.
- stim_pattern  in  DATA_W  base pattern; latched at start.
- dac_ready  in  1  DAC accepts a word.
- adc_valid  in  1  ADC sample strobe.
- adc_ch  in  CH_W  channel tag of the ADC sample.
- adc_data  in  DATA_W  ADC sample.
- dac_valid  out  1  DAC word valid.
- dac_ch  out  CH_W  target channel.
- dac_data  out  DATA_W  stimulus word.
- power_en  out  1  DUT power enable.
- busy  out  1  high in any state except IDLE.
- done  out  1  sticky completion flag.
- pass  out  1  valid when done=1.
- error_count  out  ERR_W  mismatches plus timeouts, saturating.
- timeout_count  out  ERR_W  timeouts, saturating.
- first_err_ch  out  CH_W  channel of the first error.
- first_err_cycle  out  CNT_W  cycle of the first error.

Behaviour:
- Reset: state IDLE; every output 0, including all counters and first_err_* registers.
- States: IDLE, PWR_UP, DRIVE, WAIT_ADC, CHECK, DONE.
- IDLE:
  - start=1 with abort=0: latch test_mode, max_cycles and stim_pattern. A max_cycles value of 0 is treated as 1.
  - Clear error_count, timeout_count, first_err_*, done and pass. Set busy and power_en. Go to PWR_UP.
- PWR_UP: wait PWR_DLY cycles, then go to DRIVE with ch=0, cyc=0, step=0.
- DRIVE:
  - dac_valid=1 is registered; dac_ch and dac_data are stable while valid.
  - A transfer occurs on a cycle with dac_valid & dac_ready. dac_valid is 0 the following cycle; go to WAIT_ADC with the timer cleared.
- Stimulus:
  - Mode 00: stim_pattern.
  - Modes 01 and 11: stim_pattern when cyc is even, ~stim_pattern when cyc is odd.
  - Mode 10: 1 << (step mod DATA_W).
  - Expected value = stimulus (loopback).
- WAIT_ADC:
  - adc_valid with adc_ch==ch: capture adc_data and go to CHECK.
  - adc_valid with adc_ch≠ch: ignored.
  - TIMEOUT cycles without a match: timeout_count++ and error_count++ (both saturating), record first_err_* if this is the first error, then go to CHECK flagged as already counted.
- CHECK (1 cycle):
  - On mismatch, error_count++ (saturates at all-ones). The first error latches first_err_ch=ch and first_err_cycle=cyc.
  - Advance: step++. If ch==NCH-1 then ch=0 and cyc++, otherwise ch++.
  - Mode 00 ends after ch NCH-1 of cyc 0. Modes 01 and 10 end after ch NCH-1 of cyc N-1.
  - Mode 11 never ends; cyc wraps at 2^CNT_W.
  - On end go to DONE; otherwise go to DRIVE.
- DONE (1 cycle): done=1; pass=(error_count==0 && timeout_count==0); power_en=0; busy=0 from the next cycle. Go to IDLE.
- done and pass hold until the next accepted start.
- abort in any non-IDLE state:
  - Next cycle: IDLE, dac_valid=0, power_en=0, busy=0, done=1, pass=0. Counters are frozen.
  - abort wins over a same-cycle DAC handshake or ADC match.
- start while busy: ignored. start and abort together in IDLE: no action.
- rst mid-operation: immediate return to reset values. An in-flight ADC sample is discarded.

Optional Feature:
- Macro: TEST_SEQ_CMP_MASK_EN.
- Defined:
  - Adds input port cmp_mask [DATA_W-1:0], latched at start.
  - Mismatch = |((adc_data ^ expected) & cmp_mask).
- Undefined:
  - Port absent.
  - Mismatch = (adc_data != expected).

Test Plan:
1. NCH=4, mode 00, stim_pattern=16'hA5A5, loopback returning each DAC word on the matching channel 2 cycles after transfer -> 4 transfers on ch 0..3, all A5A5; done=1, pass=1, error_count=0.
2. Mode 01, max_cycles=3, ADC corrupts ch2 on cyc1 -> 12 transfers; cyc1 words are 16'h5A5A; error_count=1, first_err_ch=2, first_err_cycle=1, pass=0.
3. TIMEOUT=8, mode 00, ADC never answers ch1 -> WAIT_ADC lasts exactly 8 cycles, then the sequence continues to ch2 and ch3; timeout_count=1, error_count=1, pass=0.
4. Mode 10, DATA_W=16, NCH=4, max_cycles=5 -> 20 words 0001,0002,…,8000,0001,…,0008; loopback clean; pass=1.
5. Mode 11, abort asserted on cycle 50 during DRIVE with dac_ready=1 -> next cycle busy=0, dac_valid=0, power_en=0, done=1, pass=0; counters unchanged.
6. ERR_W=4, mode 01, max_cycles=5, every ADC sample wrong -> error_count=15 (saturated); rst pulsed afterwards mid-WAIT_ADC -> all outputs 0 asynchronously.
